// File: rtl/ym_bus_responder.sv
// Chip-side AY-3-8910/YM2149 bus responder: synchronizes and filters BDIR/BC1/DA,
// decodes latch/write/read cycles and holds the 16-entry masked PSG register file.
module ym_bus_responder #(
  parameter logic [3:0] ADDR_HI     = 4'h0,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic       chip_sel,
  input  logic       bdir,
  input  logic       bc1,
  input  logic [7:0] da_in,
  output logic [7:0] da_out,
  output logic       da_oe,
  output logic       wr_strobe,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       env_restart,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
);

  // mode_q      | meaning
  // MODE_IDLE   | bus inactive (00)
  // MODE_READ   | CPU reading DA (01)
  // MODE_WRITE  | CPU writing data (10)
  // MODE_LATCH  | CPU latching address (11)
  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_READ  = 2'b01,
    MODE_WRITE = 2'b10,
    MODE_LATCH = 2'b11
  } mode_e;

  function automatic logic [7:0] reg_mask(input logic [3:0] a);
    case (a)
      4'd1, 4'd3, 4'd5, 4'd13: reg_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: reg_mask = 8'h1F;
      default:                 reg_mask = 8'hFF;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0]      bdir_sync_q, bdir_sync_d;
  logic [SYNC_STAGES-1:0]      bc1_sync_q, bc1_sync_d;
  logic [SYNC_STAGES-1:0][7:0] da_sync_q, da_sync_d;

  mode_e      mode_q, mode_d, mode_prev_q, mode_prev_d;
  logic       armed_q, armed_d;
  logic [7:0] cap_q, cap_d;
  logic [3:0] addr_q, addr_d;
  logic       sel_q, sel_d;
  logic [7:0] regs_q [16];
  logic [7:0] regs_d [16];
  logic       wr_strobe_q, wr_strobe_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       env_restart_q, env_restart_d;
  logic       da_oe_q, da_oe_d;
  logic [7:0] da_out_q, da_out_d;

  mode_e      mode_sync;
  logic       filt_ok;
  logic       commit_ok;
  logic       exit_latch, exit_write;
  logic [7:0] wdata;

  // Synchronizers keep running through reset so the real bus state is known at release.
  always_comb begin
    bdir_sync_d = {bdir_sync_q[SYNC_STAGES-2:0], bdir};
    bc1_sync_d  = {bc1_sync_q[SYNC_STAGES-2:0], bc1};
    da_sync_d   = {da_sync_q[SYNC_STAGES-2:0], da_in};
  end

  always_ff @(posedge cpu_clock) begin
    bdir_sync_q <= bdir_sync_d;
    bc1_sync_q  <= bc1_sync_d;
    da_sync_q   <= da_sync_d;
  end

  always_comb begin
    mode_sync   = mode_e'({bdir_sync_q[SYNC_STAGES-1], bc1_sync_q[SYNC_STAGES-1]});
    filt_ok     = {bdir_sync_q[SYNC_STAGES-1], bc1_sync_q[SYNC_STAGES-1]} ==
                  {bdir_sync_q[SYNC_STAGES-2], bc1_sync_q[SYNC_STAGES-2]};
    mode_d      = filt_ok ? mode_sync : mode_q;
    mode_prev_d = mode_q;
    // Arming needs an idle bus seen after reset, so a cycle straddling reset is dropped.
    armed_d     = armed_q | ((mode_q == MODE_IDLE) && filt_ok && (mode_sync == MODE_IDLE));
    // Hold the capture once the bus moves on, so a direct mode change keeps the old data.
    cap_d       = (((mode_q == MODE_WRITE) || (mode_q == MODE_LATCH)) && (mode_sync == mode_q))
                  ? da_sync_q[SYNC_STAGES-1] : cap_q;

    commit_ok  = armed_q && chip_sel;
    exit_latch = (mode_prev_q == MODE_LATCH) && (mode_q != MODE_LATCH);
    exit_write = (mode_prev_q == MODE_WRITE) && (mode_q != MODE_WRITE);
    wdata      = cap_q & reg_mask(addr_q);

    addr_d        = addr_q;
    sel_d         = sel_q;
    regs_d        = regs_q;
    wr_strobe_d   = 1'b0;
    env_restart_d = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;

    if (exit_latch && commit_ok) begin
      if (cap_q[7:4] == ADDR_HI) begin
        addr_d = cap_q[3:0];
        sel_d  = 1'b1;
      end else begin
        sel_d = 1'b0;
      end
    end

    if (exit_write && commit_ok && sel_q) begin
      regs_d[addr_q] = wdata;
      wr_strobe_d    = 1'b1;
      wr_addr_d      = addr_q;
      wr_data_d      = wdata;
      env_restart_d  = (addr_q == 4'd13);
    end

    da_oe_d  = (mode_q == MODE_READ) && sel_q && chip_sel && armed_q;
    da_out_d = da_oe_d ? regs_q[addr_q] : 8'h00;
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      mode_q        <= MODE_IDLE;
      mode_prev_q   <= MODE_IDLE;
      armed_q       <= 1'b0;
      cap_q         <= 8'h00;
      addr_q        <= 4'h0;
      sel_q         <= 1'b0;
      regs_q        <= '{default: 8'h00};
      wr_strobe_q   <= 1'b0;
      wr_addr_q     <= 4'h0;
      wr_data_q     <= 8'h00;
      env_restart_q <= 1'b0;
      da_oe_q       <= 1'b0;
      da_out_q      <= 8'h00;
    end else begin
      mode_q        <= mode_d;
      mode_prev_q   <= mode_prev_d;
      armed_q       <= armed_d;
      cap_q         <= cap_d;
      addr_q        <= addr_d;
      sel_q         <= sel_d;
      regs_q        <= regs_d;
      wr_strobe_q   <= wr_strobe_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      env_restart_q <= env_restart_d;
      da_oe_q       <= da_oe_d;
      da_out_q      <= da_out_d;
    end
  end

  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign env_restart = env_restart_q;
  assign da_oe       = da_oe_q;
  assign da_out      = da_out_q;
  assign rd_data     = regs_q[rd_addr];

endmodule

// File: tb/tb_ym_bus_responder.sv
// Bench for ym_bus_responder: table of latch/write vectors with a commit scoreboard,
// plus hand-written deselect, read, glitch, chip_sel and reset-mid-write sequences.
module tb_ym_bus_responder;

  logic       cpu_clock = 1'b0;
  logic       reset;
  logic       chip_sel;
  logic       bdir, bc1;
  logic [7:0] da_in;
  logic [7:0] da_out;
  logic       da_oe;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       env_restart;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  ym_bus_responder #(.ADDR_HI(4'h0), .SYNC_STAGES(2)) dut (
    .cpu_clock(cpu_clock), .reset(reset), .chip_sel(chip_sel),
    .bdir(bdir), .bc1(bc1), .da_in(da_in),
    .da_out(da_out), .da_oe(da_oe),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .env_restart(env_restart), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 cpu_clock = ~cpu_clock;

  localparam logic [1:0] M_IDLE = 2'b00, M_READ = 2'b01, M_WRITE = 2'b10, M_LATCH = 2'b11;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    logic       env;
  } sb_t;

  vec_t       vecs [9];
  sb_t        sb_q [$];
  logic [7:0] model [16];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       prev_strobe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample 1 ns after the edge and reconcile any commit with the scoreboard.
  task automatic tick();
    sb_t e;
    @(posedge cpu_clock);
    #1;
    if (wr_strobe) begin
      check("strobe_not_back_to_back", {31'd0, prev_strobe}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", {28'd0, wr_addr}, {28'd0, e.a});
        check("wr_data", {24'd0, wr_data}, {24'd0, e.d});
        check("env_restart", {31'd0, env_restart}, {31'd0, e.env});
      end
    end else if (env_restart) begin
      check("env_without_strobe", 32'd1, 32'd0);
    end
    prev_strobe = wr_strobe;
  endtask

  task automatic phase(input logic [1:0] m, input logic [7:0] d, input int n);
    bdir  = m[1];
    bc1   = m[0];
    da_in = d;
    repeat (n) tick();
  endtask

  task automatic latch(input logic [7:0] a);
    phase(M_LATCH, a, 5);
    phase(M_IDLE, 8'h00, 5);
  endtask

  task automatic write(input logic [7:0] d);
    phase(M_WRITE, d, 5);
    phase(M_IDLE, 8'h00, 6);
  endtask

  task automatic expect_commit(input logic [3:0] a, input logic [7:0] d);
    sb_t e;
    e.a   = a;
    e.d   = d;
    e.env = (a == 4'd13);
    sb_q.push_back(e);
    model[a] = d;
  endtask

  task automatic check_reg(input string name, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(name, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic check_all_regs(input string name);
    for (int i = 0; i < 16; i++) check_reg(name, 4'(i), model[i]);
  endtask

  initial begin
    vecs[0] = '{4'h7, 8'h38, 8'h38};
    vecs[1] = '{4'h1, 8'hFF, 8'h0F};
    vecs[2] = '{4'h6, 8'hFF, 8'h1F};
    vecs[3] = '{4'hD, 8'hAA, 8'h0A};
    vecs[4] = '{4'h2, 8'h9C, 8'h9C};
    vecs[5] = '{4'h0, 8'h12, 8'h12};
    vecs[6] = '{4'h8, 8'hE5, 8'h05};
    vecs[7] = '{4'hF, 8'hA5, 8'hA5};
    vecs[8] = '{4'hB, 8'h3C, 8'h3C};
    for (int i = 0; i < 16; i++) model[i] = 8'h00;

    reset = 1'b1; chip_sel = 1'b1; bdir = 1'b0; bc1 = 1'b0; da_in = 8'h00; rd_addr = 4'h0;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_da_oe", {31'd0, da_oe}, 32'd0);
    check("rst_da_out", {24'd0, da_out}, 32'd0);
    check("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check_all_regs("rst_regs");

    // Table: latch address, write value, scoreboard the masked commit, read it back.
    for (int i = 0; i < 9; i++) begin
      latch({4'h0, vecs[i].a});
      expect_commit(vecs[i].a, vecs[i].exp);
      write(vecs[i].d);
      check("sb_drain", sb_q.size(), 0);
      check_reg("rd_data_vec", vecs[i].a, vecs[i].exp);
    end

    // Deselect: upper nibble mismatch drops sel, write ignored, read not driven.
    latch(8'h17);
    write(8'h55);
    check_reg("deselect_reg7", 4'h7, model[7]);
    bdir = 1'b0; bc1 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("deselect_da_oe", {31'd0, da_oe}, 32'd0);
    end
    phase(M_IDLE, 8'h00, 5);

    // Read R2 (9C): da_oe from 4 clocks after raw entry, off 4 clocks after raw exit.
    latch(8'h02);
    bdir = 1'b0; bc1 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("read_da_oe", {31'd0, da_oe}, (k >= 4) ? 32'd1 : 32'd0);
      check("read_da_out", {24'd0, da_out}, (k >= 4) ? 32'h9C : 32'h00);
    end
    bdir = 1'b0; bc1 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("read_end_da_oe", {31'd0, da_oe}, (k < 4) ? 32'd1 : 32'd0);
      check("read_end_da_out", {24'd0, da_out}, (k < 4) ? 32'h9C : 32'h00);
    end

    // Glitch: one-clock 11 skew at the end of a write must not re-latch.
    latch(8'h03);
    expect_commit(4'h3, 8'h0A);
    phase(M_WRITE, 8'h5A, 5);
    phase(M_LATCH, 8'h5A, 1);
    phase(M_IDLE, 8'h00, 6);
    check("glitch_drain", sb_q.size(), 0);
    expect_commit(4'h3, 8'h07);
    write(8'h07);
    check("glitch_addr_kept", sb_q.size(), 0);
    check_reg("glitch_r3", 4'h3, 8'h07);

    // chip_sel drops mid-write: commit discarded, selection kept for the next write.
    latch(8'h05);
    phase(M_WRITE, 8'h3C, 3);
    chip_sel = 1'b0;
    phase(M_WRITE, 8'h3C, 2);
    phase(M_IDLE, 8'h00, 6);
    chip_sel = 1'b1;
    check_reg("csel_drop_r5", 4'h5, model[5]);
    expect_commit(4'h5, 8'h0B);
    write(8'h2B);
    check("csel_sel_kept", sb_q.size(), 0);

    // Reset mid-write: no commit, regs cleared, sel cleared, then normal operation.
    latch(8'h04);
    phase(M_WRITE, 8'h77, 4);
    reset = 1'b1;
    phase(M_WRITE, 8'h77, 2);
    reset = 1'b0;
    phase(M_WRITE, 8'h77, 3);
    phase(M_IDLE, 8'h00, 6);
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    check_all_regs("rst_mid_regs");
    write(8'h66);
    check_reg("rst_sel_cleared", 4'h0, 8'h00);
    latch(8'h04);
    expect_commit(4'h4, 8'h77);
    write(8'h77);
    check("rst_after_drain", sb_q.size(), 0);
    check_all_regs("final_regs");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ym_bus_responder.md
# ym_bus_responder

Synchronous AY-3-8910/YM2149 bus-cycle responder: the chip-side counterpart of the CPU-side BDIR/BC1 decoder. It samples the asynchronous PSG bus (bdir, bc1, 8-bit DA), filters and decodes bus modes, and maintains the 16-entry PSG register file with per-register width masking. It exposes write strobes and a combinational register-read port to the tone/noise/envelope generators, and drives DA during read cycles. One instance per chip; TurboSound pairs instantiate two, each gated by its own chip-select.

## Interface

- ADDR_HI, 4'h0: required upper nibble of a latched address; any other value deselects the chip.
- SYNC_STAGES, 2: synchronizer depth for bdir, bc1 and da_in; legal values 2–3.
- cpu_clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock, one reset, no async paths.
- chip_sel  in  1  TurboSound select; 0 makes the block ignore all cycles.
- bdir  in  1  async PSG bus direction.
- bc1  in  1  async PSG bus control.
- da_in  in  8  async PSG data/address bus.
- da_out  out  8  read data.
- da_oe  out  1  DA output enable.
- wr_strobe  out  1  one-cycle pulse on each register commit.
- wr_addr  out  4  address of the committed register.
- wr_data  out  8  masked value committed.
- env_restart  out  1  one-cycle pulse on any write to R13, even if the value is unchanged.
- rd_addr  in  4  generator-side read address.
- rd_data  out  8  combinational register-file read, masked.

## Operation

- Modes {bdir,bc1}: 00 INACTIVE, 01 READ, 10 WRITE, 11 LATCH.
- Mode filter: synchronized {bdir,bc1} must match for 2 consecutive clocks before mode_q updates. Skew codes lasting 1 clock (e.g. 10→11→00) are discarded.
- da_in passes through the same synchronizer depth plus one capture register. While mode_q is WRITE or LATCH, the captured value refreshes every clock.
- Commit happens on exit from a mode: the clock mode_q leaves WRITE or LATCH, the last captured value is acted on. Neither entering a mode nor holding it has any effect.
- LATCH exit:
  - If the captured [7:4] equals ADDR_HI and chip_sel=1: addr_q ← captured[3:0] and sel_q ← 1.
  - Otherwise sel_q ← 0 and addr_q is unchanged.
- WRITE exit, when sel_q=1 and chip_sel=1:
  - reg[addr_q] ← captured & mask[addr_q].
  - wr_strobe, wr_addr and wr_data are registered and valid for exactly 1 clock.
  - env_restart fires with wr_strobe when addr_q=13.
- Masks:
  - R0,R2,R4,R7,R11,R12,R14,R15: FF
  - R1,R3,R5,R13: 0F
  - R6,R8,R9,R10: 1F
- READ:
  - da_oe=1 while mode_q=READ and sel_q=1 and chip_sel=1.
  - da_out = reg[addr_q] (masked) whenever da_oe=1; otherwise da_out=00.
- chip_sel dropping to 0 mid-cycle: da_oe deasserts the next clock. The pending commit is discarded; sel_q is kept.
- Reset:
  - All registers 00, addr_q=0, sel_q=0, mode_q=INACTIVE, capture=00.
  - Outputs: wr_strobe=0, env_restart=0, da_oe=0, da_out=00, wr_addr=0, wr_data=00.
  - Reset mid-cycle aborts the cycle with no commit. A cycle already in progress when reset releases is ignored until mode_q passes through INACTIVE.
- Direct WRITE→LATCH or LATCH→WRITE, each held ≥2 clocks: treated as exit of the first mode (commit) plus entry of the second.

## Timing

- Raw bus change to mode_q update: SYNC_STAGES+1 clocks (3 at default). Minimum legal bus phase width is SYNC_STAGES+2 clocks.
- Mode exit to wr_strobe or addr_q update: 1 clock after mode_q changes. Default end-to-end latency from raw bdir/bc1 fall to strobe is 4 clocks.
- READ entry to da_oe=1: 1 clock after mode_q=READ. READ exit to da_oe=0: 1 clock after mode_q leaves READ.
- rd_data: combinational from rd_addr; it reflects a commit in the same clock wr_strobe is high.
- Back-to-back commits are separated by at least one INACTIVE or other-mode phase. wr_strobe is therefore never high two clocks in a row.

## Test plan

- Latch then write: LATCH 0x07, then WRITE 0x38 → wr_strobe 1 clock, wr_addr=7, wr_data=38; rd_addr=7 gives rd_data=38.
- Masking: LATCH 0x01, WRITE 0xFF → reg1=0F. LATCH 0x06, WRITE 0xFF → reg6=1F. LATCH 0x0D, WRITE 0xAA → reg13=0A with env_restart pulsed once.
- Deselect: LATCH 0x17 with ADDR_HI=0, then WRITE 0x55 → no strobe, reg7 unchanged, da_oe stays 0 on READ.
- Read: after reg2=0x9C, LATCH 0x02 then READ held for 6 clocks → da_oe=1 from 4 clocks after raw entry, da_out=9C; da_out=00 when the read ends.
- Glitch: WRITE phase with 1-clock 11 skew at its end, following LATCH 0x03 → commit to R3 only; addr_q unchanged, 1 strobe.
- Reset mid-write: assert reset during a WRITE phase → no strobe, all registers 00, sel_q=0; the following LATCH/WRITE sequence behaves normally.
